mont_digit_sequencer: RTL and testbench



---
 rtl/mont_pkg.sv | 48 ++++
 rtl/mont_q_digit.sv | 13 +
 rtl/mont_digit_sequencer.sv | 179 +++++++++++++++++
 tb/tb_mont_digit_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared definitions for the radix-4 Montgomery digit sequencer: mux select codes,
// FSM states and the quotient-digit helper. Optional feature macro: MONT_SKIP_ZERO_EN.
package mont_pkg;

    localparam logic [2:0] SEL_ZERO = 3'b000;
    localparam logic [2:0] SEL_M    = 3'b001;
    localparam logic [2:0] SEL_2M   = 3'b010;
    localparam logic [2:0] SEL_3M   = 3'b011;
    localparam logic [2:0] SEL_B    = 3'b100;
    localparam logic [2:0] SEL_2B   = 3'b101;
    localparam logic [2:0] SEL_3B   = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE_B,
        ST_WAIT_B,
        ST_ISSUE_M,
        ST_WAIT_M,
        ST_SHIFT,
        ST_FINISH
    } state_t;

    // q = -(c * m) mod 4, which zeroes the two accumulator LSBs once q*M is added.
    function automatic logic [1:0] q_digit(input logic [1:0] c, input logic [1:0] m);
        logic [3:0] prod;
        prod = {2'b00, c} * {2'b00, m};
        return 2'(4'd0 - prod);
    endfunction

    function automatic logic [2:0] b_select(input logic [1:0] d);
        case (d)
            2'd1:    return SEL_B;
            2'd2:    return SEL_2B;
            2'd3:    return SEL_3B;
            default: return SEL_ZERO;
        endcase
    endfunction

    function automatic logic [2:0] m_select(input logic [1:0] q);
        case (q)
            2'd1:    return SEL_M;
            2'd2:    return SEL_2M;
            2'd3:    return SEL_3M;
            default: return SEL_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/mont_q_digit.sv
// Combinational Montgomery quotient digit from accumulator LSBs and M[1:0].
// Optional feature macro: MONT_SKIP_ZERO_EN (no effect in this file).
module mont_q_digit
    import mont_pkg::*;
(
    input  logic [1:0] c_low,
    input  logic [1:0] m_low,
    output logic [1:0] q
);

    assign q = q_digit(c_low, m_low);

endmodule

// File: rtl/mont_digit_sequencer.sv
// Radix-4 Montgomery digit sequencer: walks A LSB-first and issues B/M operand selects.
// Optional feature macro: MONT_SKIP_ZERO_EN (skip zero adds instead of issuing select 000).
module mont_digit_sequencer
    import mont_pkg::*;
#(
    parameter int N = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] in_A,
    input  logic [1:0]   m_low,
    input  logic [1:0]   c_low,
    input  logic         add_done,
    output logic [2:0]   select,
    output logic         sel_valid,
    output logic         shift_en,
    output logic         busy,
    output logic         done
);

    localparam int DIGITS = N / 2;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    state_t        state_reg;
    logic [N-1:0]  a_sr_reg;
    logic [1:0]    m_reg;
    logic [1:0]    q_reg;
    logic [1:0]    c_reg;
    logic [CW-1:0] count_reg;
    logic [2:0]    select_reg;
    logic          sel_valid_reg;
    logic          shift_en_reg;
    logic          busy_reg;
    logic          done_reg;

    logic       accept;
    logic [1:0] digit_next;
    logic [1:0] m_src;
    logic [1:0] c_in;
    logic [1:0] q_val;

    state_t     entry_state;
    logic [2:0] entry_select;
    logic       entry_valid;
    logic       entry_shift;

    assign accept = start && ((state_reg == ST_IDLE) || (state_reg == ST_FINISH));

    // The next digit comes from in_A when launching, otherwise from the pre-shift register.
    assign digit_next = (state_reg == ST_SHIFT) ? a_sr_reg[3:2] : in_A[1:0];
    assign m_src      = accept ? m_low : m_reg;
    assign c_in       = (state_reg == ST_WAIT_B) ? c_low : (accept ? 2'b00 : c_reg);

    mont_q_digit u_q_digit (
        .c_low (c_in),
        .m_low (m_src),
        .q     (q_val)
    );

    // Entry into a digit, shared by the launch path and the digit-to-digit path.
    always_comb begin
        entry_state  = ST_ISSUE_B;
        entry_select = b_select(digit_next);
        entry_valid  = 1'b1;
        entry_shift  = 1'b0;
`ifdef MONT_SKIP_ZERO_EN
        if (digit_next == 2'd0) begin
            if (q_val == 2'd0) begin
                entry_state  = ST_SHIFT;
                entry_select = select_reg;
                entry_valid  = 1'b0;
                entry_shift  = 1'b1;
            end else begin
                entry_state  = ST_ISSUE_M;
                entry_select = m_select(q_val);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            a_sr_reg      <= '0;
            m_reg         <= 2'b00;
            q_reg         <= 2'b00;
            c_reg         <= 2'b00;
            count_reg     <= '0;
            select_reg    <= SEL_ZERO;
            sel_valid_reg <= 1'b0;
            shift_en_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            sel_valid_reg <= 1'b0;
            shift_en_reg  <= 1'b0;
            done_reg      <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_FINISH: begin
                    if (start) begin
                        a_sr_reg      <= in_A;
                        m_reg         <= m_low;
                        c_reg         <= 2'b00;
                        count_reg     <= '0;
                        busy_reg      <= 1'b1;
                        state_reg     <= entry_state;
                        select_reg    <= entry_select;
                        sel_valid_reg <= entry_valid;
                        shift_en_reg  <= entry_shift;
`ifdef MONT_SKIP_ZERO_EN
                        q_reg         <= q_val;
`endif
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_ISSUE_B: state_reg <= ST_WAIT_B;
                ST_WAIT_B: begin
                    if (add_done) begin
                        q_reg <= q_val;
                        c_reg <= c_low;
`ifdef MONT_SKIP_ZERO_EN
                        if (q_val == 2'd0) begin
                            state_reg    <= ST_SHIFT;
                            shift_en_reg <= 1'b1;
                        end else begin
                            state_reg     <= ST_ISSUE_M;
                            select_reg    <= m_select(q_val);
                            sel_valid_reg <= 1'b1;
                        end
`else
                        state_reg     <= ST_ISSUE_M;
                        select_reg    <= m_select(q_val);
                        sel_valid_reg <= 1'b1;
`endif
                    end
                end
                ST_ISSUE_M: begin
                    select_reg <= m_select(q_reg);
                    state_reg  <= ST_WAIT_M;
                end
                ST_WAIT_M: begin
                    if (add_done) begin
                        state_reg    <= ST_SHIFT;
                        shift_en_reg <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    a_sr_reg  <= a_sr_reg >> 2;
                    count_reg <= count_reg + CW'(1);
                    if (count_reg == LAST) begin
                        state_reg  <= ST_FINISH;
                        select_reg <= SEL_ZERO;
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                    end else begin
                        state_reg     <= entry_state;
                        select_reg    <= entry_select;
                        sel_valid_reg <= entry_valid;
                        shift_en_reg  <= entry_shift;
`ifdef MONT_SKIP_ZERO_EN
                        q_reg         <= q_val;
`endif
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign select    = select_reg;
    assign sel_valid = sel_valid_reg;
    assign shift_en  = shift_en_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_mont_digit_sequencer.sv
// Scoreboard bench for mont_digit_sequencer with a randomized adder responder.
// Optional feature macro: MONT_SKIP_ZERO_EN (expected event stream follows it).
module tb_mont_digit_sequencer;

    localparam int N = 8;
    localparam int D = N / 2;
    localparam int EV_SHIFT = 8;
    localparam int EV_DONE  = 16;
`ifdef MONT_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] in_A;
    logic [1:0]   m_low;
    logic [1:0]   c_low;
    logic         add_done;
    logic [2:0]   select;
    logic         sel_valid;
    logic         shift_en;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;
    int op_no = 0;
    int exp_q[$];
    int resp_q[$];

    always #5 clk = ~clk;

    mont_digit_sequencer #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_A      (in_A),
        .m_low     (m_low),
        .c_low     (c_low),
        .add_done  (add_done),
        .select    (select),
        .sel_valid (sel_valid),
        .shift_en  (shift_en),
        .busy      (busy),
        .done      (done)
    );

    // Reference rules: q = (4 - (c*m mod 4)) mod 4; B code 100+d-1 for d!=0.
    function automatic int qf(input int c, input int m);
        return (4 - ((c * m) % 4)) % 4;
    endfunction

    function automatic int bsel(input int d);
        return (d == 0) ? 0 : 4 + d - 1;
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every sel_valid / shift_en / done pulse consumes one expected event.
    always @(negedge clk) begin
        int ev;
        if (!reset && (sel_valid || shift_en || done)) begin
            ev = sel_valid ? int'(select) : (shift_en ? EV_SHIFT : EV_DONE);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event actual=%0d required=none", ev);
            end else begin
                check("event", ev, exp_q.pop_front());
            end
        end
    end

    // Adder responder: completes each issued add after 0..3 idle cycles, adds stray pulses.
    initial begin
        bit pending;
        int delay;
        int cur_c;
        pending  = 1'b0;
        delay    = 0;
        cur_c    = 0;
        add_done = 1'b0;
        c_low    = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            add_done = 1'b0;
            c_low    = 2'($urandom_range(0, 3));
            if (reset) begin
                pending  = 1'b0;
                add_done = 1'($urandom_range(0, 1));
            end else if (sel_valid) begin
                cur_c   = (resp_q.size() != 0) ? resp_q.pop_front() : 0;
                pending = 1'b1;
                delay   = $urandom_range(0, 3);
                if ($urandom_range(0, 3) == 0) add_done = 1'b1;
            end else if (pending) begin
                if (delay == 0) begin
                    add_done = 1'b1;
                    c_low    = 2'(cur_c);
                    pending  = 1'b0;
                end else begin
                    delay--;
                end
            end else if ((shift_en || !busy) && $urandom_range(0, 3) == 0) begin
                add_done = 1'b1;
            end
        end
    end

    // Called at a negedge with the DUT not busy; returns at the negedge showing done.
    task automatic do_op(input logic [N-1:0] a, input int m, input int cfix);
        int  c_prev, d, c, q, d0;
        bit  got;
        c_prev = 0;
        d0     = int'(a[1:0]);
        for (int i = 0; i < D; i++) begin
            d = int'(a[2*i +: 2]);
            c = (cfix >= 0) ? cfix : $urandom_range(0, 3);
            if (!SKIP || d != 0) begin
                exp_q.push_back(bsel(d));
                resp_q.push_back(c);
                c_prev = c;
            end
            q = qf(c_prev, m);
            if (!SKIP || q != 0) begin
                exp_q.push_back(q);
                resp_q.push_back($urandom_range(0, 3));
            end
            exp_q.push_back(EV_SHIFT);
        end
        exp_q.push_back(EV_DONE);

        start = 1'b1;
        in_A  = a;
        m_low = 2'(m);
        @(posedge clk);
        #1;
        start = 1'b0;
        in_A  = N'($urandom);
        m_low = 2'($urandom_range(0, 3));
        check("busy_after_start", int'(busy), 1);
`ifdef MONT_SKIP_ZERO_EN
        if (d0 != 0) check("first_sel_valid", int'(sel_valid), 1);
`else
        check("first_sel_valid", int'(sel_valid), 1);
`endif
        got = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            start = busy && ($urandom_range(0, 7) == 0);
            in_A  = N'($urandom);
            m_low = 2'($urandom_range(0, 3));
        end
        start = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL op_timeout actual=no_done required=done");
            exp_q.delete();
            resp_q.delete();
        end else begin
            check("busy_at_done", int'(busy), 0);
        end
        op_no++;
        $display("op %0d A=%h m=%0d pending_events=%0d", op_no, a, m, exp_q.size());
    endtask

    task automatic reset_in_wait_m();
        int n;
        exp_q.push_back(bsel(3));
        exp_q.push_back(qf(1, 1));
        resp_q.push_back(1);
        resp_q.push_back(0);
        start = 1'b1;
        in_A  = 8'hFF;
        m_low = 2'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 50 && n < 2; cyc++) begin
            @(negedge clk);
            if (sel_valid) n++;
        end
        check("reached_issue_m", n, 2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_sel_valid", int'(sel_valid), 0);
        check("abort_select", int'(select), 0);
        reset = 1'b0;
        exp_q.delete();
        resp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_done_after_abort", int'(done), 0);
        end
        $display("op reset_in_wait_m aborted");
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        in_A  = '0;
        m_low = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_select", int'(select), 0);
        check("reset_sel_valid", int'(sel_valid), 0);
        check("reset_shift_en", int'(shift_en), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_busy", int'(busy), 0);
            check("idle_sel_valid", int'(sel_valid), 0);
        end

        do_op(8'h0E, 1, -1);
        do_op(8'hFF, 3, 1);
        do_op(8'hFF, 3, 3);
        do_op(8'h00, 1, 0);
        do_op(8'h1B, 1, 0);
        for (int i = 0; i < 25; i++) begin
            do_op(N'($urandom), ($urandom_range(0, 1) * 2) + 1, -1);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        reset_in_wait_m();
        do_op(8'h01, 3, -1);

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        total++;
        bad++;
        $display("FAIL watchdog actual=running required=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
